spike_aer_encoder: RTL

Collects the `spike_o` pulses of a layer of `neuron` instances and serialises them into address-event (AER) words, one neuron index per word. Spikes that arrive in the same cycle are arbitrated round-robin. Granted events are buffered in a small FIFO and drained over a valid/ready handshake to the next layer's axon fan-out logic. The block sits directly downstream of the neuron array.

---
 rtl/snn_pkg.sv | 36 +++
 rtl/aer_fifo.sv | 60 ++++++
 rtl/spike_aer_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: drop-counter sizing and a reusable round-robin picker.
package snn_pkg;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Widest request vector the round-robin picker handles.
    localparam int RR_MAX_W = 64;
    localparam int RR_IDX_W = $clog2(RR_MAX_W);

    // One-hot grant of the first set bit of pending[n-1:0], searching upward
    // from ptr and wrapping from n-1 back to 0. All-zero when nothing is set.
    function automatic logic [RR_MAX_W-1:0] f_rr_pick(
        input logic [RR_MAX_W-1:0] pending,
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_IDX_W:0]   n = (RR_IDX_W+1)'(RR_MAX_W)
    );
        logic [RR_MAX_W-1:0] grant;
        logic                found;
        logic [RR_IDX_W:0]   idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_W; k++) begin
            if (k < int'(n)) begin
                idx = {1'b0, ptr} + (RR_IDX_W+1)'(k);
                if (idx >= n) idx = idx - n;
                if (!found && pending[idx[RR_IDX_W-1:0]]) begin
                    grant[idx[RR_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/aer_fifo.sv
// Synchronous FIFO holding AER words; head word is shown while not empty.
module aer_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push;
    logic             do_pop;

    // Flags decode the count register only, so they change one edge after a push/pop.
    assign full_o  = (count_r == CNT_W'(DEPTH));
    assign empty_o = (count_r == '0);
    assign count_o = count_r;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head word forced to zero when empty so the address output is defined out of reset.
    assign data_o = empty_o ? '0 : mem_r[rd_ptr_r];

    // Storage write.
    // NOTE: the data array has no reset; only pointers and count decide what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_r[wr_ptr_r] <= data_i;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: pending bit set, round-robin arbiter, output FIFO.
// Optional feature macro: SNN_AER_DROP_CNT_EN adds the saturating drop counter and drop_cnt_o.
module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter  int NUM_NEURONS = 16,
    parameter  int FIFO_DEPTH  = 8,
    localparam int ADDR_W      = $clog2(NUM_NEURONS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_NEURONS-1:0] spike_i,
    output logic                   aer_valid_o,
    input  logic                   aer_ready_i,
    output logic [ADDR_W-1:0]      aer_addr_o,
    output logic                   fifo_full_o
`ifdef SNN_AER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_NEURONS-1:0] pending_r;
    logic [ADDR_W-1:0]      ptr_r;
    logic [RR_MAX_W-1:0]    pend_ext;
    logic [RR_MAX_W-1:0]    grant_ext;
    logic [NUM_NEURONS-1:0] grant;
    logic                   grant_valid;
    logic [ADDR_W-1:0]      grant_idx;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   can_grant;

    // No grant at all while the FIFO is full; a same-cycle pop does not make room.
    assign can_grant = (fifo_count < CNT_W'(FIFO_DEPTH));

    // Present pending requests to the shared picker, masked off when there is no room.
    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        pend_ext = '0;
        if (can_grant) pend_ext[NUM_NEURONS-1:0] = pending_r;
    end

    assign grant_ext   = f_rr_pick(pend_ext, RR_IDX_W'(ptr_r), (RR_IDX_W+1)'(NUM_NEURONS));
    assign grant       = grant_ext[NUM_NEURONS-1:0];
    assign grant_valid = |grant;

    if (NUM_NEURONS < RR_MAX_W) begin : g_rr_tail
        logic unused_grant_hi;
        assign unused_grant_hi = |grant_ext[RR_MAX_W-1:NUM_NEURONS];
    end

    // One-hot grant to neuron index for the AER word.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (grant[i]) grant_idx = ADDR_W'(i);
        end
    end

    // Pending set keeps ungranted spikes; a granted bit re-arms if it spikes again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_r <= '0;
            ptr_r     <= '0;
        end else begin
            pending_r <= (pending_r & ~grant) | spike_i;
            if (grant_valid) begin
                ptr_r <= (grant_idx == ADDR_W'(NUM_NEURONS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

`ifdef SNN_AER_DROP_CNT_EN
    logic [NUM_NEURONS-1:0] drop_vec;
    logic [DROP_CNT_W-1:0]  drop_cnt_r;
    logic [DROP_CNT_W:0]    drop_sum;

    // A spike is lost when its bit is already pending and not being granted now.
    assign drop_vec = spike_i & pending_r & ~grant;
    assign drop_sum = {1'b0, drop_cnt_r} + (DROP_CNT_W+1)'($countones(drop_vec));

    // Saturating count of lost spikes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_r <= '0;
        end else if (drop_sum > {1'b0, DROP_CNT_MAX}) begin
            drop_cnt_r <= DROP_CNT_MAX;
        end else begin
            drop_cnt_r <= drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign drop_cnt_o = drop_cnt_r;
`endif

    assign aer_valid_o = !fifo_empty;

    aer_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant_valid),
        .data_i  (grant_idx),
        .pop_i   (aer_valid_o && aer_ready_i),
        .data_o  (aer_addr_o),
        .full_o  (fifo_full_o),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
